// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_pkg
// Description : Register map and control-bit constants for pulse_seq_multi.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_seq_pkg;

    localparam int A_PERIOD   = 0;
    localparam int A_SYNC_UP  = 1;
    localparam int A_ATT_DOWN = 2;
    localparam int A_ATT      = 3;
    localparam int A_ALT      = 4;
    localparam int A_CTRL     = 5;
    localparam int A_CH_BASE  = 8;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_COMMIT = 1;

    // Channel i owns START at the returned address and WIDTH at the next one.
    function automatic int ch_start_addr(input int idx);
        return A_CH_BASE + 2 * idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_chan.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_chan
// Description : One pulse channel: staged/active window, comparator, alt gate.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_chan #(
    parameter int CW = 32
) (
    input  logic          clk_pll,
    input  logic          reset,
    input  logic          we_start,
    input  logic          we_width,
    input  logic [CW-1:0] wdata,
    input  logic          copy,
    input  logic [CW-1:0] cnt,
    input  logic          alt,
    input  logic          parity,
    input  logic          en,
    output logic          ch_out
);

    logic [CW-1:0] r_start_stg;
    logic [CW-1:0] r_width_stg;
    logic [CW-1:0] r_start_act;
    logic [CW-1:0] r_width_act;
    logic [CW:0]   w_end;
    logic          w_hit;

    // One extra bit keeps start+width from wrapping past the counter range.
    assign w_end = {1'b0, r_start_act} + {1'b0, r_width_act};
    assign w_hit = (cnt >= r_start_act) && ({1'b0, cnt} < w_end) && !(alt && parity);

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            r_start_stg <= '0;
            r_width_stg <= '0;
            r_start_act <= '0;
            r_width_act <= '0;
            ch_out      <= 1'b0;
        end else begin
            if (copy) begin
                r_start_act <= r_start_stg;
                r_width_act <= r_width_stg;
            end
            if (we_start) r_start_stg <= wdata;
            if (we_width) r_width_stg <= wdata;
            ch_out <= en && w_hit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_seq_multi.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_multi
// Description : Multi-channel pulse sequencer with atomic period-boundary commit.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_multi
    import pulse_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CW         = 32,
    parameter int ATT_W      = 7,
    parameter int DEF_PERIOD = 20000,
    parameter int AW         = 5
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CW-1:0]    cfg_wdata,
    output logic [NCH-1:0]   ch_out,
    output logic             sync_on,
    output logic [ATT_W-1:0] att,
    output logic             period_start,
    output logic             parity,
    output logic             commit_pending
);

    logic [CW-1:0]    r_cnt;
    logic             r_running;
    logic             r_parity;
    logic             r_pending;

    logic [CW-1:0]    r_period_stg,   r_period_act;
    logic [CW-1:0]    r_sync_stg,     r_sync_act;
    logic [CW-1:0]    r_att_down_stg, r_att_down_act;
    logic [ATT_W-1:0] r_att_pulse_stg, r_att_pulse_act;
    logic [ATT_W-1:0] r_att_post_stg,  r_att_post_act;
    logic [NCH-1:0]   r_alt_stg,      r_alt_act;

    logic             w_ctrl_we;
    logic             w_run_next;
    logic             w_commit;
    logic             w_en;
    logic [CW-1:0]    w_period_eff;
    logic             w_wrap;
    logic             w_copy;

    assign w_ctrl_we    = cfg_we && (cfg_addr == AW'(A_CTRL));
    assign w_run_next   = w_ctrl_we ? cfg_wdata[CTRL_RUN] : r_running;
    assign w_commit     = w_ctrl_we && cfg_wdata[CTRL_COMMIT];
    // Clearing run blanks outputs and the counter on the same edge.
    assign w_en         = r_running && w_run_next;
    assign w_period_eff = (r_period_act < CW'(2)) ? CW'(2) : r_period_act;
    assign w_wrap       = r_running && (r_cnt >= (w_period_eff - CW'(1)));
    assign w_copy       = r_pending && (!r_running || w_wrap);

    assign parity         = r_parity;
    assign commit_pending = r_pending;

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            r_cnt           <= '0;
            r_running       <= 1'b0;
            r_parity        <= 1'b0;
            r_pending       <= 1'b0;
            r_period_stg    <= CW'(DEF_PERIOD);
            r_period_act    <= CW'(DEF_PERIOD);
            r_sync_stg      <= '0;
            r_sync_act      <= '0;
            r_att_down_stg  <= '0;
            r_att_down_act  <= '0;
            r_att_pulse_stg <= '0;
            r_att_pulse_act <= '0;
            r_att_post_stg  <= '0;
            r_att_post_act  <= '0;
            r_alt_stg       <= '0;
            r_alt_act       <= '0;
            sync_on         <= 1'b0;
            att             <= '0;
            period_start    <= 1'b0;
        end else begin
            // Active copy uses pre-write staging; a same-cycle write stays staged.
            if (w_copy) begin
                r_period_act    <= r_period_stg;
                r_sync_act      <= r_sync_stg;
                r_att_down_act  <= r_att_down_stg;
                r_att_pulse_act <= r_att_pulse_stg;
                r_att_post_act  <= r_att_post_stg;
                r_alt_act       <= r_alt_stg;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    AW'(A_PERIOD):   r_period_stg   <= cfg_wdata;
                    AW'(A_SYNC_UP):  r_sync_stg     <= cfg_wdata;
                    AW'(A_ATT_DOWN): r_att_down_stg <= cfg_wdata;
                    AW'(A_ATT): begin
                        r_att_pulse_stg <= cfg_wdata[ATT_W-1:0];
                        r_att_post_stg  <= cfg_wdata[2*ATT_W-1:ATT_W];
                    end
                    AW'(A_ALT):      r_alt_stg      <= cfg_wdata[NCH-1:0];
                    default: ;
                endcase
            end
            r_pending <= w_commit || (r_pending && !w_copy);
            r_running <= w_run_next;

            if (!w_en) begin
                r_cnt <= '0;
            end else if (w_wrap) begin
                r_cnt    <= '0;
                r_parity <= ~r_parity;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            sync_on      <= w_en && (r_cnt >= r_sync_act);
            att          <= (w_en && (r_cnt < r_att_down_act)) ? r_att_pulse_act : r_att_post_act;
            period_start <= w_en && (r_cnt == '0);
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        pulse_seq_chan #(
            .CW(CW)
        ) u_chan (
            .clk_pll  (clk_pll),
            .reset    (reset),
            .we_start (cfg_we && (cfg_addr == AW'(ch_start_addr(gi)))),
            .we_width (cfg_we && (cfg_addr == AW'(ch_start_addr(gi) + 1))),
            .wdata    (cfg_wdata),
            .copy     (w_copy),
            .cnt      (r_cnt),
            .alt      (r_alt_act[gi]),
            .parity   (r_parity),
            .en       (w_en),
            .ch_out   (ch_out[gi])
        );
    end

endmodule
`default_nettype wire

// File: doc/pulse_seq_multi.md
Name: pulse_seq_multi

Overview:
Parametrised multi-channel pulse sequencer, successor to the fixed two-pulse generator.
- A free-running period counter drives NCH independent pulse channels, a sync output and an attenuator word.
- Timing values are written over a register interface into staging registers and committed atomically at a period boundary, so a running sequence never sees a torn update.
- Per-channel alternate mode gates a channel to every other period, for pump-on/pump-off interleaving.

Parameters:
NCH, 4, number of pulse channels (1..8)
CW, 32, counter/timing width in clk_pll cycles
ATT_W, 7, attenuator word width
DEF_PERIOD, 20000, period loaded at reset
AW, 5, config address width

Ports:
clk_pll  in  1  sole clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_addr  in  AW  config register address
cfg_wdata  in  CW  config write data
ch_out  out  NCH  channel pulse outputs
sync_on  out  1  sync pulse
att  out  ATT_W  attenuator control word
period_start  out  1  one-cycle strobe on the first cycle of each period
parity  out  1  period parity (toggles each period)
commit_pending  out  1  a commit is waiting for the period boundary

Behaviour:
- Reset (synchronous, active-high): cnt=0, running=0, parity=0, commit_pending=0; all outputs 0; att=0.
  - Active and staging registers: period=DEF_PERIOD; all other registers 0.
- Register map (staging, write-only):
  - 0 PERIOD
  - 1 SYNC_UP
  - 2 ATT_DOWN
  - 3 ATT: [ATT_W-1:0]=att_pulse, [2*ATT_W-1:ATT_W]=att_post
  - 4 ALT_MASK: [NCH-1:0]
  - 5 CTRL: bit0=run, bit1=commit; writes take effect next cycle; run is not staged
  - 8+2i CH_i_START
  - 9+2i CH_i_WIDTH
  - Writes to unmapped addresses are ignored.
- Effective period is max(PERIOD, 2).
- Counter, while running: cnt increments each cycle; when cnt == period-1 it wraps to 0 and parity toggles.
  - When not running, cnt holds 0.
- Commit:
  - CTRL.commit sets commit_pending.
  - If running, staging is copied to active on the wrap cycle (the new values govern cnt=0 onward) and pending clears.
  - If stopped, the copy happens the next cycle.
  - A staging write in the same cycle as the copy is not included; it stays staged.
  - A commit write in the copy cycle re-arms pending.
- Channel i, combinational term: hit_i = (cnt >= start_i) && ({1'b0,cnt} < {1'b0,start_i}+{1'b0,width_i}), computed at CW+1 bits, so there is no wrap.
  - width_i=0 gives never high.
  - If ALT_MASK[i]=1, hit_i is also ANDed with (parity==0).
- sync term = cnt >= sync_up. att term = (cnt < att_down) ? att_pulse : att_post.
- All outputs are registered: each output reflects the cnt value of the previous cycle, a fixed 1-cycle latency. period_start=1 in the cycle after cnt==0.
- Outputs are forced 0 while running=0. att is the exception: it holds att_post while stopped.
- Clearing run mid-period: the counter goes to 0 the next cycle and the outputs drop at the same time. Setting run again restarts at cnt=0 with parity unchanged.
- Pulses with start+width > period are truncated at the wrap.
- Reset mid-operation discards staging and pending commits.

Decomposition:
- Package pulse_seq_pkg holds the register address constants (A_PERIOD, A_SYNC_UP, A_ATT_DOWN, A_ATT, A_ALT, A_CTRL, A_CH_BASE) and CTRL bit indices.
- Sub-module pulse_seq_chan holds one channel: staging and active start/width registers, the commit copy, the windowed comparator, alt gating and the output register. It is instantiated NCH times via generate.

Test Plan:
1. Reset, then write PERIOD=100, CH0 start=10 width=5, commit, run=1. ch_out[0] is high when the cycle-lagged cnt is 10..14; period_start pulses every 100 cycles.
2. Running with PERIOD=100, write CH0 start=50 and commit at cnt=30. The current period still pulses at 10; the change takes effect from the next wrap; commit_pending is high for the intervening cycles.
3. Set ALT_MASK=0b0010 with CH1 start=0 width=3. CH1 pulses only in periods with parity=0; CH0 pulses every period.
4. Boundary cases: PERIOD=1 runs as period 2; CH2 start=0xFFFFFFF0 width=0x20 gives no overflow glitch (ch_out[2] never high with period 100); width=0 gives never high.
5. ATT=pulse 7'h7F / post 7'h00, ATT_DOWN=40. att=7F for cnt 0..39 and 00 after; with run=0, att=00.
6. Assert reset at cnt=57 while a commit is pending. The next cycle all outputs are 0, cnt=0, running=0, commit_pending=0, and period has returned to 20000.
